// File: rtl/bcd_score_display.sv
// BCD score counter with a best-score register, feeding a multiplexed common-anode
// 7-segment display that shows the score, the best score or the game-over message.
module bcd_score_display #(
    parameter int NDIGITS  = 4,
    parameter int SCAN_DIV = 4,
    parameter int SATURATE = 0,
    parameter int BLANK_LZ = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   inc,
    input  logic [3:0]             add_val,
    input  logic                   clear,
    input  logic                   lose,
    input  logic                   show_best,
    output logic [4*NDIGITS-1:0]   score_bcd,
    output logic [4*NDIGITS-1:0]   best_bcd,
    output logic                   overflow,
    output logic [NDIGITS-1:0]     anodes,
    output logic [6:0]             cathodes
);

    localparam int W  = 4 * NDIGITS;
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    // Cathode patterns, active-low, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        logic [6:0] s;
        s = SEG_BLANK;
        case (d)
            4'd0: s = 7'b1000000;
            4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;
            4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;
            4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;
            4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;
            4'd9: s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    logic [W-1:0]      score_reg, score_next;
    logic [W-1:0]      best_reg, best_next;
    logic              overflow_reg, overflow_next;
    logic              lose_q_reg;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [IW-1:0]     idx_reg, idx_next, idx_inc;
    logic [NDIGITS-1:0] anodes_reg, anodes_next, anodes_sel;
    logic [6:0]        cathodes_reg, cathodes_next;

    logic [3:0]        add_clamped;
    logic [W-1:0]      sum_bcd;
    logic [NDIGITS:0]  carry;
    logic [W-1:0]      disp_val;
    logic [6:0]        pos_seg [NDIGITS];

    assign add_clamped = (add_val > 4'd9) ? 4'd9 : add_val;
    assign carry[0]    = 1'b0;

    // Ripple BCD adder: the clamped addend enters digit 0, carries ripple upward.
    genvar gi;
    generate
        for (gi = 0; gi < NDIGITS; gi++) begin : g_add
            logic [4:0] addend;
            logic [4:0] raw;
            logic [4:0] adj;
            if (gi == 0) begin : g_lsd
                assign addend = {1'b0, add_clamped};
            end else begin : g_upper
                assign addend = {4'b0000, carry[gi]};
            end
            assign raw            = {1'b0, score_reg[4*gi +: 4]} + addend;
            assign adj            = raw - 5'd10;
            assign carry[gi+1]    = (raw > 5'd9);
            assign sum_bcd[4*gi +: 4] = carry[gi+1] ? adj[3:0] : raw[3:0];
        end
    endgenerate

    always_comb begin
        score_next    = score_reg;
        overflow_next = 1'b0;
        if (clear) begin
            score_next = '0;
        end else if (lose) begin
            score_next = score_reg;
        end else if (inc) begin
            if (carry[NDIGITS]) begin
                overflow_next = 1'b1;
                score_next    = (SATURATE != 0) ? {NDIGITS{4'h9}} : sum_bcd;
            end else begin
                score_next = sum_bcd;
            end
        end
    end

    // Packed BCD orders the same as its decimal value, so a plain unsigned compare works.
    always_comb begin
        best_next = best_reg;
        if (lose && !lose_q_reg && (score_reg > best_reg)) begin
            best_next = score_reg;
        end
    end

    assign disp_val = show_best ? best_reg : score_reg;

    generate
        for (gi = 0; gi < NDIGITS; gi++) begin : g_pos
            logic [6:0] msg_seg;
            logic       blank;
            if (gi == 3) begin : g_m3
                assign msg_seg = SEG_D;
            end else if (gi == 2) begin : g_m2
                assign msg_seg = SEG_E;
            end else if (gi == 1) begin : g_m1
                assign msg_seg = SEG_A;
            end else if (gi == 0) begin : g_m0
                assign msg_seg = SEG_D;
            end else begin : g_mb
                assign msg_seg = SEG_BLANK;
            end
            if (gi == 0 || BLANK_LZ == 0) begin : g_noblank
                assign blank = 1'b0;
            end else begin : g_lz
                assign blank = (disp_val[W-1:4*gi] == '0);
            end
            assign pos_seg[gi] = lose  ? msg_seg :
                                 blank ? SEG_BLANK :
                                         digit_seg(disp_val[4*gi +: 4]);
            assign anodes_sel[gi] = (idx_inc != IW'(gi));
        end
    endgenerate

    assign idx_inc = (idx_reg == IW'(NDIGITS - 1)) ? '0 : idx_reg + 1'b1;

    // Anodes and cathodes are loaded together at the scan step, so no ghost cycle exists.
    always_comb begin
        cnt_next      = cnt_reg;
        idx_next      = idx_reg;
        anodes_next   = anodes_reg;
        cathodes_next = cathodes_reg;
        if (enable) begin
            if (cnt_reg == CW'(SCAN_DIV - 1)) begin
                cnt_next      = '0;
                idx_next      = idx_inc;
                anodes_next   = anodes_sel;
                cathodes_next = pos_seg[idx_inc];
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            score_reg    <= '0;
            best_reg     <= '0;
            overflow_reg <= 1'b0;
            lose_q_reg   <= 1'b0;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            anodes_reg   <= '1;
            cathodes_reg <= '1;
        end else begin
            score_reg    <= score_next;
            best_reg     <= best_next;
            overflow_reg <= overflow_next;
            lose_q_reg   <= lose;
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            anodes_reg   <= anodes_next;
            cathodes_reg <= cathodes_next;
        end
    end

    assign score_bcd = score_reg;
    assign best_bcd  = best_reg;
    assign overflow  = overflow_reg;
    assign anodes    = anodes_reg;
    assign cathodes  = cathodes_reg;

endmodule

// File: tb/tb_bcd_score_display.sv
// Randomized and directed bench for bcd_score_display: a wrap/fast-scan instance and a
// saturate/slow-scan instance share stimulus and are compared against a decimal model.
module tb_bcd_score_display;

    localparam int N = 4;
    localparam int DIV [2] = '{1, 3};
    localparam int SAT [2] = '{0, 1};

    logic clk = 1'b0;
    logic reset, enable, inc, clear, lose, show_best;
    logic [3:0] add_val;
    logic [15:0] score0, score1, best0, best1;
    logic overflow0, overflow1;
    logic [3:0] anodes0, anodes1;
    logic [6:0] cathodes0, cathodes1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_score_display #(.NDIGITS(4), .SCAN_DIV(1), .SATURATE(0), .BLANK_LZ(1)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .inc(inc), .add_val(add_val),
        .clear(clear), .lose(lose), .show_best(show_best), .score_bcd(score0),
        .best_bcd(best0), .overflow(overflow0), .anodes(anodes0), .cathodes(cathodes0));

    bcd_score_display #(.NDIGITS(4), .SCAN_DIV(3), .SATURATE(1), .BLANK_LZ(1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .inc(inc), .add_val(add_val),
        .clear(clear), .lose(lose), .show_best(show_best), .score_bcd(score1),
        .best_bcd(best1), .overflow(overflow1), .anodes(anodes1), .cathodes(cathodes1));

    // Reference model state: plain decimal integers plus the scan position.
    int       m_score [2];
    int       m_best  [2];
    bit       m_ovf   [2];
    int       m_cnt   [2];
    int       m_idx   [2];
    logic [3:0] m_an  [2];
    logic [6:0] m_cat [2];
    bit       m_loseq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int p;
        p = 1;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Lit patterns written a..g from MSB to LSB, then mapped to active-low {g..a}.
    function automatic logic [6:0] lit_to_cat(input logic [6:0] lit);
        logic [6:0] c;
        for (int j = 0; j < 7; j++) c[j] = ~lit[6-j];
        return c;
    endfunction

    function automatic logic [6:0] glyph(input int code);
        logic [6:0] lit;
        case (code)
            0: lit = 7'b1111110;  1: lit = 7'b0110000;  2: lit = 7'b1101101;
            3: lit = 7'b1111001;  4: lit = 7'b0110011;  5: lit = 7'b1011011;
            6: lit = 7'b1011111;  7: lit = 7'b1110000;  8: lit = 7'b1111111;
            9: lit = 7'b1111011;  10: lit = 7'b0111101; 11: lit = 7'b1001111;
            12: lit = 7'b1110111; default: lit = 7'b0000000;
        endcase
        return lit_to_cat(lit);
    endfunction

    function automatic logic [6:0] model_cat(input int k, input int pos);
        int v, p;
        if (lose) begin
            case (pos)
                3, 0: return glyph(10);
                2:    return glyph(11);
                1:    return glyph(12);
                default: return glyph(-1);
            endcase
        end
        v = show_best ? m_best[k] : m_score[k];
        p = 1;
        for (int i = 0; i < pos; i++) p = p * 10;
        if (pos > 0 && v < p) return glyph(-1);
        return glyph((v / p) % 10);
    endfunction

    task automatic model_step();
        int s;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_score[k] = 0; m_best[k] = 0; m_ovf[k] = 0;
                m_cnt[k] = 0; m_idx[k] = 0; m_an[k] = 4'hF; m_cat[k] = 7'h7F;
                continue;
            end
            if (enable) begin
                if (m_cnt[k] + 1 == DIV[k]) begin
                    m_cnt[k] = 0;
                    m_idx[k] = (m_idx[k] + 1) % N;
                    m_an[k]  = ~(4'b0001 << m_idx[k]);
                    m_cat[k] = model_cat(k, m_idx[k]);
                end else begin
                    m_cnt[k]++;
                end
            end
            if (lose && !m_loseq && m_score[k] > m_best[k]) m_best[k] = m_score[k];
            m_ovf[k] = 0;
            if (clear) begin
                m_score[k] = 0;
            end else if (!lose && inc) begin
                s = m_score[k] + ((add_val > 9) ? 9 : int'(add_val));
                if (s > 9999) begin
                    m_ovf[k] = 1;
                    m_score[k] = SAT[k] ? 9999 : s - 10000;
                end else begin
                    m_score[k] = s;
                end
            end
        end
        m_loseq = reset ? 1'b0 : lose;
    endtask

    task automatic check_all();
        check("score0", 32'(score0), 32'(to_bcd(m_score[0])));
        check("score1", 32'(score1), 32'(to_bcd(m_score[1])));
        check("best0", 32'(best0), 32'(to_bcd(m_best[0])));
        check("best1", 32'(best1), 32'(to_bcd(m_best[1])));
        check("ovf0", 32'(overflow0), 32'(m_ovf[0]));
        check("ovf1", 32'(overflow1), 32'(m_ovf[1]));
        check("anodes0", 32'(anodes0), 32'(m_an[0]));
        check("anodes1", 32'(anodes1), 32'(m_an[1]));
        check("cath0", 32'(cathodes0), 32'(m_cat[0]));
        check("cath1", 32'(cathodes1), 32'(m_cat[1]));
    endtask

    // Drives one clock of stimulus from a falling edge and checks at the next falling edge.
    task automatic cycle(input bit rs, input bit en, input bit inc_i, input logic [3:0] add,
                         input bit clr, input bit ls, input bit sb);
        reset = rs; enable = en; inc = inc_i; add_val = add;
        clear = clr; lose = ls; show_best = sb;
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic add_n(input int n, input logic [3:0] add);
        for (int i = 0; i < n; i++) cycle(0, 1'($urandom_range(0, 1)), 1, add, 0, 0, 0);
    endtask

    logic [3:0] an_exp [4];
    logic [6:0] cat_exp [4];

    initial begin
        reset = 1; enable = 0; inc = 0; add_val = 0; clear = 0; lose = 0; show_best = 0;
        m_loseq = 0;
        @(negedge clk);
        cycle(1, 0, 0, 0, 0, 0, 0);
        check("reset_an", 32'(anodes0), 32'h0000000F);
        check("reset_cat", 32'(cathodes0), 32'h0000007F);

        // Count and carry through several digits
        add_n(1011, 4'd1);
        check("t1_score", 32'(score0), 32'h00001011);

        // Wrap versus saturate
        cycle(1, 0, 0, 0, 0, 0, 0);
        add_n(1110, 4'd9);
        add_n(1, 4'd8);
        check("t2_pre", 32'(score1), 32'h00009998);
        add_n(1, 4'd5);
        check("t2_wrap", 32'(score0), 32'h00000003);
        check("t2_wrap_ovf", 32'(overflow0), 32'd1);
        check("t2_sat", 32'(score1), 32'h00009999);
        check("t2_sat_ovf", 32'(overflow1), 32'd1);
        add_n(1, 4'd1);
        check("t2_sat_hold", 32'(score1), 32'h00009999);
        check("t2_sat_ovf2", 32'(overflow1), 32'd1);

        // Clamp and priority
        cycle(1, 0, 0, 0, 0, 0, 0);
        add_n(1, 4'd15);
        check("t3_clamp", 32'(score0), 32'h00000009);
        cycle(0, 0, 1, 4'd3, 1, 0, 0);
        check("t3_clear", 32'(score0), 32'h00000000);
        add_n(1, 4'd5);
        cycle(0, 0, 1, 4'd4, 0, 1, 0);
        check("t3_lose_hold", 32'(score0), 32'h00000005);

        // Best-score capture
        cycle(1, 0, 0, 0, 0, 0, 0);
        add_n(4, 4'd9);
        add_n(1, 4'd6);
        cycle(0, 0, 0, 0, 0, 1, 0);
        check("t4_best42", 32'(best0), 32'h00000042);
        cycle(0, 0, 0, 0, 1, 0, 0);
        add_n(1, 4'd9);
        add_n(1, 4'd8);
        cycle(0, 0, 0, 0, 0, 1, 0);
        check("t4_best_keep", 32'(best1), 32'h00000042);
        cycle(1, 0, 0, 0, 0, 1, 0);
        check("t4_best_rst", 32'(best0), 32'h00000000);

        // Scan with leading-zero blanking
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 4'd7, 0, 0, 0);
        an_exp  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        cat_exp = '{7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000};
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 0, 0, 0, 0, 0);
            check("t5_an", 32'(anodes0), 32'(an_exp[i]));
            check("t5_cat", 32'(cathodes0), 32'(cat_exp[i]));
        end

        // Game-over message, show_best ignored
        cat_exp = '{7'b0001000, 7'b0000110, 7'b0100001, 7'b0100001};
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 0, 0, 0, 1, 1'(i));
            check("t6_cat", 32'(cathodes0), 32'(cat_exp[i]));
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 15) == 0) ? !lose : lose,
                  1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
